// File: rtl/rca_cfg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca_cfg_bank_pkg
//  Description : Shared types and constants for the per-RCA configuration
//                store: field selector, configuration record, commit states.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca_cfg_bank_pkg;

    // Default geometry; the record layout below is built from these values.
    localparam int DEF_NUM_RCAS        = 4;
    localparam int DEF_NUM_READ_PORTS  = 5;
    localparam int DEF_NUM_WRITE_PORTS = 2;
    localparam int DEF_NUM_IO_UNITS    = 8;
    localparam int DEF_XLEN            = 32;

    localparam int MUX_W     = $clog2(DEF_NUM_IO_UNITS + 1);
    localparam int MAX_PORTS = (DEF_NUM_READ_PORTS > DEF_NUM_WRITE_PORTS) ?
                               DEF_NUM_READ_PORTS : DEF_NUM_WRITE_PORTS;
    localparam int CFG_IDX_W = $clog2(MAX_PORTS);

    // Result-mux select value meaning "no IO unit drives this write port".
    localparam logic [MUX_W-1:0] UNUSED_WRITE_PORT_ADDR = MUX_W'(DEF_NUM_IO_UNITS);

    typedef enum logic [2:0] {
        SRC_ADDR      = 3'd0,
        DEST_FB_ADDR  = 3'd1,
        DEST_NFB_ADDR = 3'd2,
        RES_MUX_FB    = 3'd3,
        RES_MUX_NFB   = 3'd4,
        IO_INP_MAP    = 3'd5,
        LS_MASK_FB    = 3'd6,
        LS_MASK_NFB   = 3'd7
    } cfg_field_t;

    typedef struct packed {
        logic [DEF_NUM_READ_PORTS-1:0][4:0]        src_addr;
        logic [DEF_NUM_WRITE_PORTS-1:0][4:0]       dest_fb_addr;
        logic [DEF_NUM_WRITE_PORTS-1:0][4:0]       dest_nfb_addr;
        logic [DEF_NUM_WRITE_PORTS-1:0][MUX_W-1:0] res_mux_fb;
        logic [DEF_NUM_WRITE_PORTS-1:0][MUX_W-1:0] res_mux_nfb;
        logic [DEF_NUM_IO_UNITS-1:0]               io_inp_map;
        logic [DEF_NUM_IO_UNITS-1:0]               ls_mask_fb;
        logic [DEF_NUM_IO_UNITS-1:0]               ls_mask_nfb;
    } rca_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_COPY  = 2'd2
    } commit_state_t;

    // Power-on record: everything zero except the result-mux selects,
    // which park on the "unused" code so no IO unit is routed by default.
    function automatic rca_cfg_t cfg_reset_value();
        rca_cfg_t r;
        r = '0;
        for (int i = 0; i < DEF_NUM_WRITE_PORTS; i++) begin
            r.res_mux_fb[i]  = UNUSED_WRITE_PORT_ADDR;
            r.res_mux_nfb[i] = UNUSED_WRITE_PORT_ADDR;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_cfg_bank_commit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rca_cfg_commit_fsm
//  Description : Commit sequencer for the configuration bank. Waits for the
//                target RCA to drain, then issues a one-cycle copy/ack.
//                Also produces the valid-bit set/clear strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_cfg_commit_fsm
    import rca_cfg_bank_pkg::*;
#(
    parameter int NUM_RCAS = DEF_NUM_RCAS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commit_req_i,
    input  logic                        inval_req_i,
    input  logic [$clog2(NUM_RCAS)-1:0] commit_rca_i,
    input  logic [NUM_RCAS-1:0]         rca_inflight_i,
    output commit_state_t               state_o,
    output logic [$clog2(NUM_RCAS)-1:0] pend_rca_o,
    output logic                        busy_o,
    output logic                        commit_ack_o,
    output logic                        copy_en_o,
    output logic                        valid_clr_o,
    output logic [$clog2(NUM_RCAS)-1:0] valid_clr_rca_o,
    output logic                        valid_set_o
);

    commit_state_t                 state_q, state_d;
    logic [$clog2(NUM_RCAS)-1:0]   pend_q, pend_d;

    // State and pending-RCA registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic; invalidate wins over commit, both only heard in IDLE.
    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        valid_clr_o     = 1'b0;
        valid_clr_rca_o = commit_rca_i;
        case (state_q)
            ST_IDLE: begin
                if (inval_req_i) begin
                    valid_clr_o = 1'b1;
                end else if (commit_req_i) begin
                    // Drop valid as DRAIN is entered so nothing new dispatches
                    // onto a record that is about to change.
                    valid_clr_o = 1'b1;
                    pend_d      = commit_rca_i;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rca_inflight_i[pend_q]) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_o      = state_q;
    assign pend_rca_o   = pend_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign copy_en_o    = (state_q == ST_COPY);
    assign commit_ack_o = (state_q == ST_COPY);
    assign valid_set_o  = (state_q == ST_COPY);

endmodule
`default_nettype wire

// File: rtl/rca_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : rca_cfg_bank
//  Description : Double-buffered per-RCA configuration store. Writes land in
//                shadow records; a commit copies shadow to active once the
//                RCA has drained. Readers see active records combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_cfg_bank
    import rca_cfg_bank_pkg::*;
#(
    parameter int NUM_RCAS        = DEF_NUM_RCAS,
    parameter int NUM_READ_PORTS  = DEF_NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = DEF_NUM_WRITE_PORTS,
    parameter int NUM_IO_UNITS    = DEF_NUM_IO_UNITS,
    parameter int XLEN            = DEF_XLEN
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_wr_valid,
    output logic                                   cfg_wr_ready,
    input  logic [$clog2(NUM_RCAS)-1:0]            cfg_wr_rca,
    input  cfg_field_t                             cfg_wr_field,
    input  logic [CFG_IDX_W-1:0]                   cfg_wr_idx,
    input  logic [XLEN-1:0]                        cfg_wr_data,
    input  logic                                   commit_req,
    output logic                                   commit_ack,
    input  logic [$clog2(NUM_RCAS)-1:0]            commit_rca,
    input  logic                                   inval_req,
    input  logic [NUM_RCAS-1:0]                    rca_inflight,
    output logic                                   busy,
    output logic [NUM_RCAS-1:0]                    cfg_valid,
    input  logic [$clog2(NUM_RCAS)-1:0]            rca_sel_decode,
    input  logic [$clog2(NUM_RCAS)-1:0]            rca_sel_grid_wb,
    input  logic [$clog2(NUM_RCAS)-1:0]            rca_sel_buf,
    input  logic                                   use_fb_decode,
    output logic [NUM_READ_PORTS-1:0][4:0]         src_addrs_decode,
    output logic [NUM_WRITE_PORTS-1:0][4:0]        dest_addrs_decode,
    output logic [NUM_WRITE_PORTS-1:0][$clog2(NUM_IO_UNITS+1)-1:0] res_mux_fb_wb,
    output logic [NUM_WRITE_PORTS-1:0][$clog2(NUM_IO_UNITS+1)-1:0] res_mux_nfb_wb,
    output logic [NUM_IO_UNITS-1:0]                ls_mask_fb_wb,
    output logic [NUM_IO_UNITS-1:0]                ls_mask_nfb_wb,
    output logic [NUM_IO_UNITS-1:0]                io_inp_map_buf
);

    rca_cfg_t                      shadow_q [NUM_RCAS];
    rca_cfg_t                      active_q [NUM_RCAS];
    rca_cfg_t                      shadow_wr_d;
    logic [NUM_RCAS-1:0]           valid_q, valid_d;

    commit_state_t                 fsm_state;
    logic [$clog2(NUM_RCAS)-1:0]   pend_rca;
    logic                          copy_en;
    logic                          valid_clr;
    logic [$clog2(NUM_RCAS)-1:0]   valid_clr_rca;
    logic                          valid_set;
    logic                          wr_fire;
    logic                          unused_wr_data;

    rca_cfg_commit_fsm #(
        .NUM_RCAS (NUM_RCAS)
    ) u_commit_fsm (
        .clk             (clk),
        .rst             (rst),
        .commit_req_i    (commit_req),
        .inval_req_i     (inval_req),
        .commit_rca_i    (commit_rca),
        .rca_inflight_i  (rca_inflight),
        .state_o         (fsm_state),
        .pend_rca_o      (pend_rca),
        .busy_o          (busy),
        .commit_ack_o    (commit_ack),
        .copy_en_o       (copy_en),
        .valid_clr_o     (valid_clr),
        .valid_clr_rca_o (valid_clr_rca),
        .valid_set_o     (valid_set)
    );

    // Only the RCA being committed is locked against writes.
    assign cfg_wr_ready   = !(busy && (cfg_wr_rca == pend_rca));
    assign wr_fire        = cfg_wr_valid && cfg_wr_ready;
    // High data bits beyond the widest field are intentionally discarded.
    assign unused_wr_data = ^cfg_wr_data;

    // Merge the incoming write into the addressed shadow record; an index
    // past the field's port count matches no slot and the write is dropped.
    always_comb begin
        shadow_wr_d = shadow_q[cfg_wr_rca];
        case (cfg_wr_field)
            SRC_ADDR: begin
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (int'(cfg_wr_idx) == i) shadow_wr_d.src_addr[i] = cfg_wr_data[4:0];
                end
            end
            DEST_FB_ADDR: begin
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (int'(cfg_wr_idx) == i) shadow_wr_d.dest_fb_addr[i] = cfg_wr_data[4:0];
                end
            end
            DEST_NFB_ADDR: begin
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (int'(cfg_wr_idx) == i) shadow_wr_d.dest_nfb_addr[i] = cfg_wr_data[4:0];
                end
            end
            RES_MUX_FB: begin
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (int'(cfg_wr_idx) == i) shadow_wr_d.res_mux_fb[i] = cfg_wr_data[MUX_W-1:0];
                end
            end
            RES_MUX_NFB: begin
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (int'(cfg_wr_idx) == i) shadow_wr_d.res_mux_nfb[i] = cfg_wr_data[MUX_W-1:0];
                end
            end
            IO_INP_MAP:  shadow_wr_d.io_inp_map  = cfg_wr_data[NUM_IO_UNITS-1:0];
            LS_MASK_FB:  shadow_wr_d.ls_mask_fb  = cfg_wr_data[NUM_IO_UNITS-1:0];
            LS_MASK_NFB: shadow_wr_d.ls_mask_nfb = cfg_wr_data[NUM_IO_UNITS-1:0];
            default: ;
        endcase
    end

    // Shadow storage: one record updated per accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RCAS; i++) shadow_q[i] <= cfg_reset_value();
        end else if (wr_fire) begin
            shadow_q[cfg_wr_rca] <= shadow_wr_d;
        end
    end

    // Active storage: whole-record copy during COPY keeps the update atomic.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RCAS; i++) active_q[i] <= cfg_reset_value();
        end else if (copy_en) begin
            active_q[pend_rca] <= shadow_q[pend_rca];
        end
    end

    // Valid bits: cleared on invalidate/DRAIN entry, set on COPY.
    always_comb begin
        valid_d = valid_q;
        if (valid_clr) valid_d[valid_clr_rca] = 1'b0;
        if (valid_set) valid_d[pend_rca]      = 1'b1;
    end

    // Valid register.
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    assign cfg_valid = valid_q;

    // Combinational read ports; sources only exist on the fb path.
    assign src_addrs_decode  = use_fb_decode ? active_q[rca_sel_decode].src_addr : '0;
    assign dest_addrs_decode = use_fb_decode ? active_q[rca_sel_decode].dest_fb_addr
                                             : active_q[rca_sel_decode].dest_nfb_addr;
    assign res_mux_fb_wb     = active_q[rca_sel_grid_wb].res_mux_fb;
    assign res_mux_nfb_wb    = active_q[rca_sel_grid_wb].res_mux_nfb;
    assign ls_mask_fb_wb     = active_q[rca_sel_grid_wb].ls_mask_fb;
    assign ls_mask_nfb_wb    = active_q[rca_sel_grid_wb].ls_mask_nfb;
    assign io_inp_map_buf    = active_q[rca_sel_buf].io_inp_map;

`ifndef SYNTHESIS
    a_ack_only_in_copy: assert property (@(posedge clk) disable iff (rst)
        commit_ack |-> (fsm_state == ST_COPY));
    a_active_wr_only_in_copy: assert property (@(posedge clk) disable iff (rst)
        copy_en |-> (fsm_state == ST_COPY));
    a_not_ready_targets_pend: assert property (@(posedge clk) disable iff (rst)
        !cfg_wr_ready |-> (cfg_wr_rca == pend_rca));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rca_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_cfg_bank
//  Description : Self-checking bench for rca_cfg_bank: commit scoreboard,
//                table of read-port vectors and hand-written corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_cfg_bank;
    import rca_cfg_bank_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_wr_valid;
    logic             cfg_wr_ready;
    logic [1:0]       cfg_wr_rca;
    cfg_field_t       cfg_wr_field;
    logic [2:0]       cfg_wr_idx;
    logic [31:0]      cfg_wr_data;
    logic             commit_req;
    logic             commit_ack;
    logic [1:0]       commit_rca;
    logic             inval_req;
    logic [3:0]       rca_inflight;
    logic             busy;
    logic [3:0]       cfg_valid;
    logic [1:0]       rca_sel_decode;
    logic [1:0]       rca_sel_grid_wb;
    logic [1:0]       rca_sel_buf;
    logic             use_fb_decode;
    logic [4:0][4:0]  src_addrs_decode;
    logic [1:0][4:0]  dest_addrs_decode;
    logic [1:0][3:0]  res_mux_fb_wb;
    logic [1:0][3:0]  res_mux_nfb_wb;
    logic [7:0]       ls_mask_fb_wb;
    logic [7:0]       ls_mask_nfb_wb;
    logic [7:0]       io_inp_map_buf;

    always #5 clk = ~clk;

    rca_cfg_bank dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_wr_valid      (cfg_wr_valid),
        .cfg_wr_ready      (cfg_wr_ready),
        .cfg_wr_rca        (cfg_wr_rca),
        .cfg_wr_field      (cfg_wr_field),
        .cfg_wr_idx        (cfg_wr_idx),
        .cfg_wr_data       (cfg_wr_data),
        .commit_req        (commit_req),
        .commit_ack        (commit_ack),
        .commit_rca        (commit_rca),
        .inval_req         (inval_req),
        .rca_inflight      (rca_inflight),
        .busy              (busy),
        .cfg_valid         (cfg_valid),
        .rca_sel_decode    (rca_sel_decode),
        .rca_sel_grid_wb   (rca_sel_grid_wb),
        .rca_sel_buf       (rca_sel_buf),
        .use_fb_decode     (use_fb_decode),
        .src_addrs_decode  (src_addrs_decode),
        .dest_addrs_decode (dest_addrs_decode),
        .res_mux_fb_wb     (res_mux_fb_wb),
        .res_mux_nfb_wb    (res_mux_nfb_wb),
        .ls_mask_fb_wb     (ls_mask_fb_wb),
        .ls_mask_nfb_wb    (ls_mask_nfb_wb),
        .io_inp_map_buf    (io_inp_map_buf)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int chk_valid_rca = -1;

    typedef struct {
        int rca;
        int ack_cyc;
    } ack_exp_t;
    ack_exp_t ack_q [$];

    typedef struct {
        logic [1:0]      dec;
        logic            fb;
        logic [1:0]      wb;
        logic [1:0]      bsel;
        logic [4:0][4:0] src;
        logic [1:0][4:0] dest;
        logic [1:0][3:0] rmfb;
        logic [1:0][3:0] rmnfb;
        logic [7:0]      lsfb;
        logic [7:0]      lsnfb;
        logic [7:0]      map;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: commit-ack monitor on the falling edge, then advance.
    task automatic cycle();
        logic [3:0] v;
        @(negedge clk);
        if (chk_valid_rca >= 0) begin
            v = cfg_valid;
            chk("valid_after_ack", 32'(v[2'(chk_valid_rca)]), 32'd1);
            chk_valid_rca = -1;
        end
        if (commit_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 32'(commit_ack), 32'd0);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                chk_valid_rca = e.rca;
            end
        end else if (ack_q.size() > 0 && cyc >= ack_q[0].ack_cyc) begin
            chk("ack_missing", 32'(commit_ack), 32'd1);
            void'(ack_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int rca, input cfg_field_t f, input int idx,
                      input logic [31:0] d, input logic exp_ready);
        cfg_wr_valid = 1'b1;
        cfg_wr_rca   = 2'(rca);
        cfg_wr_field = f;
        cfg_wr_idx   = 3'(idx);
        cfg_wr_data  = d;
        #1;
        chk("wr_ready", 32'(cfg_wr_ready), 32'(exp_ready));
        cycle();
        cfg_wr_valid = 1'b0;
    endtask

    // Commit with no inflight work: ack expected two cycles after the request.
    task automatic commit_fast(input int rca);
        commit_req = 1'b1;
        commit_rca = 2'(rca);
        ack_q.push_back('{rca, cyc + 2});
        cycle();
        commit_req = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        rst = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_rca = '0; cfg_wr_field = SRC_ADDR;
        cfg_wr_idx = '0; cfg_wr_data = '0; commit_req = 1'b0; commit_rca = '0;
        inval_req = 1'b0; rca_inflight = '0; rca_sel_decode = '0;
        rca_sel_grid_wb = '0; rca_sel_buf = '0; use_fb_decode = 1'b1;

        // Reset values
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("rst_valid",   32'(cfg_valid), 32'h0);
        chk("rst_resmux",  32'(res_mux_fb_wb), 32'h88);
        chk("rst_resmuxn", 32'(res_mux_nfb_wb), 32'h88);
        chk("rst_src",     32'(src_addrs_decode), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_ack",     32'(commit_ack), 32'h0);

        // Staging isolation and basic commit latency
        wr(1, SRC_ADDR, 2, 32'd17, 1'b1);
        rca_sel_decode = 2'd1;
        #1;
        chk("stage_isolated", 32'(src_addrs_decode[2]), 32'd0);
        commit_req = 1'b1; commit_rca = 2'd1;
        ack_q.push_back('{1, cyc + 2});
        cycle();
        commit_req = 1'b0;
        #1;
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_src",  32'(src_addrs_decode[2]), 32'd0);
        cycle();
        #1;
        chk("c2_ack", 32'(commit_ack), 32'd1);
        chk("c2_src", 32'(src_addrs_decode[2]), 32'd0);
        cycle();
        #1;
        chk("c3_src",   32'(src_addrs_decode[2]), 32'd17);
        chk("c3_valid", 32'(cfg_valid), 32'h2);
        chk("c3_busy",  32'(busy), 32'd0);

        // Populate RCA 2 and commit it
        wr(2, DEST_FB_ADDR,  0, 32'd9,  1'b1);
        wr(2, DEST_NFB_ADDR, 1, 32'd3,  1'b1);
        wr(2, RES_MUX_FB,    1, 32'd5,  1'b1);
        wr(2, IO_INP_MAP,    0, 32'h3C, 1'b1);
        commit_fast(2);
        chk("rca2_valid", 32'(cfg_valid), 32'h6);

        // Drain stall on RCA 2 with concurrent writes
        rca_inflight = 4'b0100;
        cycle(); cycle();
        commit_req = 1'b1; commit_rca = 2'd2;
        cycle();
        commit_req = 1'b0;
        #1;
        chk("drain_valid_clr", 32'(cfg_valid[2]), 32'd0);
        chk("drain_busy",      32'(busy), 32'd1);
        wr(2, SRC_ADDR, 0, 32'd11, 1'b0);
        wr(3, LS_MASK_FB, 0, 32'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            inval_req  = (i == 0);
            commit_rca = 2'd1;
            #1;
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_ack",  32'(commit_ack), 32'd0);
            cycle();
        end
        inval_req = 1'b0;
        #1;
        chk("busy_ignores_inval", 32'(cfg_valid[1]), 32'd1);
        rca_inflight = 4'b0000;
        ack_q.push_back('{2, cyc + 1});
        chk("drop_busy", 32'(busy), 32'd1);
        cycle();
        #1;
        chk("stall_ack_hi",  32'(commit_ack), 32'd1);
        chk("stall_busy_hi", 32'(busy), 32'd1);
        cycle();
        #1;
        chk("stall_done_busy",  32'(busy), 32'd0);
        chk("stall_done_valid", 32'(cfg_valid), 32'h6);

        // Commit RCA 3 and read its fb load/store mask
        commit_fast(3);
        rca_sel_grid_wb = 2'd3;
        #1;
        chk("rca3_lsmask", 32'(ls_mask_fb_wb), 32'hA5);
        chk("rca3_valid",  32'(cfg_valid), 32'hE);

        // Invalidate keeps the active record
        inval_req = 1'b1; commit_rca = 2'd1;
        cycle();
        inval_req = 1'b0;
        rca_sel_decode = 2'd1; use_fb_decode = 1'b1;
        #1;
        chk("inval_valid", 32'(cfg_valid), 32'hC);
        chk("inval_keep",  32'(src_addrs_decode[2]), 32'd17);
        chk("inval_busy",  32'(busy), 32'd0);

        // Out-of-range indices are acked but dropped
        wr(1, SRC_ADDR, 7, 32'd31, 1'b1);
        wr(1, SRC_ADDR, 5, 32'd30, 1'b1);
        wr(1, SRC_ADDR, 4, 32'd21, 1'b1);
        wr(1, DEST_FB_ADDR, 2, 32'd7, 1'b1);
        commit_fast(1);
        chk("bounds_valid", 32'(cfg_valid), 32'hE);

        // Read-port vector table
        vt[0] = '{2'd1, 1'b1, 2'd0, 2'd0, {5'd21, 5'd0, 5'd17, 5'd0, 5'd0}, 10'd0,
                  8'h88, 8'h88, 8'h00, 8'h00, 8'h00};
        vt[1] = '{2'd1, 1'b0, 2'd1, 2'd1, 25'd0, 10'd0,
                  8'h88, 8'h88, 8'h00, 8'h00, 8'h00};
        vt[2] = '{2'd2, 1'b1, 2'd2, 2'd2, 25'd0, {5'd0, 5'd9},
                  8'h58, 8'h88, 8'h00, 8'h00, 8'h3C};
        vt[3] = '{2'd2, 1'b0, 2'd3, 2'd3, 25'd0, {5'd3, 5'd0},
                  8'h88, 8'h88, 8'hA5, 8'h00, 8'h00};
        vt[4] = '{2'd0, 1'b1, 2'd2, 2'd0, 25'd0, 10'd0,
                  8'h58, 8'h88, 8'h00, 8'h00, 8'h00};
        vt[5] = '{2'd3, 1'b1, 2'd3, 2'd2, 25'd0, 10'd0,
                  8'h88, 8'h88, 8'hA5, 8'h00, 8'h3C};
        for (int i = 0; i < 6; i++) begin
            rca_sel_decode  = vt[i].dec;
            use_fb_decode   = vt[i].fb;
            rca_sel_grid_wb = vt[i].wb;
            rca_sel_buf     = vt[i].bsel;
            #1;
            chk($sformatf("vec%0d_src", i),   32'(src_addrs_decode),  32'(vt[i].src));
            chk($sformatf("vec%0d_dest", i),  32'(dest_addrs_decode), 32'(vt[i].dest));
            chk($sformatf("vec%0d_rmfb", i),  32'(res_mux_fb_wb),     32'(vt[i].rmfb));
            chk($sformatf("vec%0d_rmnfb", i), 32'(res_mux_nfb_wb),    32'(vt[i].rmnfb));
            chk($sformatf("vec%0d_lsfb", i),  32'(ls_mask_fb_wb),     32'(vt[i].lsfb));
            chk($sformatf("vec%0d_lsnfb", i), 32'(ls_mask_nfb_wb),    32'(vt[i].lsnfb));
            chk($sformatf("vec%0d_map", i),   32'(io_inp_map_buf),    32'(vt[i].map));
            cycle();
        end

        // Reset while draining: no ack, everything back to reset values
        rca_inflight = 4'b1000;
        commit_req = 1'b1; commit_rca = 2'd3;
        cycle();
        commit_req = 1'b0;
        #1;
        chk("rstmid_busy_pre", 32'(busy), 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rca_sel_decode = 2'd1; use_fb_decode = 1'b1;
        rca_sel_grid_wb = 2'd3; rca_sel_buf = 2'd2;
        #1;
        chk("rstmid_busy",   32'(busy), 32'd0);
        chk("rstmid_ack",    32'(commit_ack), 32'd0);
        chk("rstmid_valid",  32'(cfg_valid), 32'h0);
        chk("rstmid_src",    32'(src_addrs_decode), 32'h0);
        chk("rstmid_lsfb",   32'(ls_mask_fb_wb), 32'h0);
        chk("rstmid_resmux", 32'(res_mux_fb_wb), 32'h88);
        chk("rstmid_map",    32'(io_inp_map_buf), 32'h0);
        rca_inflight = 4'b0000;
        cycle(); cycle(); cycle();
        chk("scoreboard_drained", 32'(ack_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rca_cfg_bank.md
# rca_cfg_bank

Double-buffered, parametrised per-RCA configuration store for the reconfigurable accelerator subsystem. Configuration writes land in a per-RCA shadow record and are committed atomically to the active record only once that RCA has no instructions in flight. Decode, grid-writeback and buffer stages read active records combinationally, and a per-RCA valid bit gates dispatch. It sits between the RCA configuration-instruction unit (writer) and the decode/issue/writeback paths (readers).

## Interface
- NUM_RCAS, 4, number of accelerator slots (≥2, power of two)
- NUM_READ_PORTS, 5, CPU source registers per RCA
- NUM_WRITE_PORTS, 2, CPU destination registers per RCA
- NUM_IO_UNITS, 8, IO units; result-mux select width is $clog2(NUM_IO_UNITS+1)
- XLEN, 32, configuration write data width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_wr_valid / cfg_wr_ready  in/out  1  shadow-write handshake; a write occurs when both are high
- cfg_wr_rca  in  $clog2(NUM_RCAS)  target RCA
- cfg_wr_field  in  cfg_field_t  SRC_ADDR, DEST_FB_ADDR, DEST_NFB_ADDR, RES_MUX_FB, RES_MUX_NFB, IO_INP_MAP, LS_MASK_FB, LS_MASK_NFB
- cfg_wr_idx  in  CFG_IDX_W  port index, ignored for map and mask fields
- cfg_wr_data  in  XLEN  value, truncated to the field width
- commit_req / commit_ack  in/out  1  commit request and its one-cycle completion pulse
- commit_rca  in  $clog2(NUM_RCAS)  RCA to commit, sampled with commit_req
- inval_req  in  1  clears cfg_valid[commit_rca] without copying
- rca_inflight  in  NUM_RCAS  per-RCA "instructions outstanding" from issue tracking
- busy  out  1  FSM not in IDLE
- cfg_valid  out  NUM_RCAS  active record committed
- rca_sel_decode, rca_sel_grid_wb, rca_sel_buf  in  $clog2(NUM_RCAS)  read selects
- use_fb_decode  in  1  select fb destinations and supply sources
- src_addrs_decode  out  [NUM_READ_PORTS][5]  zero when use_fb_decode=0
- dest_addrs_decode  out  [NUM_WRITE_PORTS][5]
- res_mux_fb_wb, res_mux_nfb_wb  out  [NUM_WRITE_PORTS][$clog2(NUM_IO_UNITS+1)]
- ls_mask_fb_wb, ls_mask_nfb_wb  out  NUM_IO_UNITS
- io_inp_map_buf  out  NUM_IO_UNITS  read via rca_sel_buf

## Operation
- Storage: shadow[NUM_RCAS] and active[NUM_RCAS] of rca_cfg_t. Reset value: all address fields 0, all masks and maps 0, result-mux selects UNUSED_WRITE_PORT_ADDR (= NUM_IO_UNITS), cfg_valid = 0.
- Shadow write: on handshake, the addressed field/index of shadow[cfg_wr_rca] is updated. The field decides the index range. SRC_ADDR with idx ≥ NUM_READ_PORTS, or DEST/RES_MUX with idx ≥ NUM_WRITE_PORTS, is dropped and err_pulse is not required. The write is still acked.
- cfg_wr_ready = !(state != IDLE && cfg_wr_rca == pend_rca). Writes to other RCAs proceed during a commit.
- FSM states:
  - IDLE: commit_req → DRAIN, latching pend_rca. inval_req takes priority over commit_req; it clears the valid bit in the same cycle and stays in IDLE.
  - DRAIN: when !rca_inflight[pend_rca], go to COPY. Before that, cfg_valid[pend_rca] is cleared on DRAIN entry so no new dispatch targets a half-updated RCA.
  - COPY: active[pend_rca] ← shadow[pend_rca], cfg_valid[pend_rca] ← 1, commit_ack = 1, → IDLE.
- commit_req and inval_req are ignored while busy.
- Reads are combinational from the active records, independent of the FSM.

## Timing
- Shadow write is visible in shadow at the next edge. It never reaches the outputs until a COPY.
- Commit latency with rca_inflight already 0:
  - cycle 0: req sampled
  - cycle 1: DRAIN, valid cleared
  - cycle 2: COPY with ack high
  - cycle 3: new outputs visible, valid = 1
- Each extra cycle of inflight adds one cycle.
- rst mid-commit: returns to IDLE with no ack, and all records reset.
- A simultaneous shadow write to pend_rca during COPY is blocked by ready = 0.

## Structure
- rca_config package gains rca_cfg_t (packed struct), cfg_field_t enum, CFG_IDX_W = $clog2(max(NUM_READ_PORTS, NUM_WRITE_PORTS)), UNUSED_WRITE_PORT_ADDR.
- One sub-module: rca_cfg_commit_fsm (states, pend_rca, busy, ack, valid set/clear strobes). Storage and read muxing stay in rca_cfg_bank.
- Assertions:
  - commit_ack is only ever in COPY
  - no active write outside COPY
  - cfg_wr_ready low implies target == pend_rca

## Test plan
- Reset check: rst for 2 cycles → cfg_valid = 0, res_mux_fb_wb all 8 (NUM_IO_UNITS = 8), src_addrs_decode all 0.
- Staging isolation: write SRC_ADDR rca 1 idx 2 = 5'd17, then read with rca_sel_decode = 1 and use_fb_decode = 1 → src[2] stays 0 until commit. Commit rca 1 with inflight = 0 → ack on cycle 2, src[2] = 17 on cycle 3, cfg_valid = 4'b0010.
- Drain stall: rca_inflight[2] = 1 for 5 cycles, then commit rca 2 → cfg_valid[2] low from cycle 1, ack exactly one cycle after inflight falls, busy high throughout.
- Concurrent writes: during the rca 2 DRAIN, write rca 2 → ready = 0; write rca 3 LS_MASK_FB = 8'hA5 → accepted. Commit rca 3 later → ls_mask_fb_wb = 8'hA5 with rca_sel_grid_wb = 3.
- Invalidate and bounds: inval_req with commit_rca 1 → cfg_valid[1] = 0 next cycle, active record unchanged. A SRC_ADDR write with idx 7 is ignored.
- Reset mid-commit: assert rst in DRAIN → busy = 0, no ack, all outputs at reset values next cycle.
